// File: rtl/time_entry_register.sv
// Keypad time entry: synchronizes the encoder key-valid level, detects presses and shifts
// BCD digits right-to-left into an MM:SS register. Optional hold-off guarded by DEBOUNCE_EN.
module time_entry_register #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] BCD_IN,
    input  logic       loadn,
    input  logic       clr,
    input  logic       enablen,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [2:0] digit_count,
    output logic [1:0] entry_state,
    output logic       key_ack,
    output logic       time_zero,
    output logic       time_valid
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ENTRY = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic             load_s1;
    logic             load_s2;
    logic             load_s3;
    logic [3:0]       bcd_s1;
    logic [3:0]       bcd_s2;
    logic             press;
    logic             digit_ok;
    logic             has_room;
    logic             holdoff_clear;
    logic             accept;
    logic [2:0]       next_count;
    logic [CNT_W-1:0] holdoff_cnt;

    // The digit pipeline runs beside the loadn synchronizer so bcd_s2 is the digit seen with load_s2.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_s1 <= 1'b0;
            load_s2 <= 1'b0;
            load_s3 <= 1'b0;
            bcd_s1  <= 4'd0;
            bcd_s2  <= 4'd0;
        end else begin
            load_s1 <= loadn;
            load_s2 <= load_s1;
            load_s3 <= load_s2;
            bcd_s1  <= BCD_IN;
            bcd_s2  <= bcd_s1;
        end
    end

    assign press      = load_s2 & ~load_s3;
    assign digit_ok   = (bcd_s2 <= 4'd9);
    assign has_room   = (digit_count < 3'd4);
    assign next_count = digit_count + 3'd1;

`ifdef DEBOUNCE_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            holdoff_cnt <= '0;
        end else if (clr) begin
            holdoff_cnt <= '0;
        end else if (accept) begin
            holdoff_cnt <= CNT_W'(DEBOUNCE_CYCLES);
        end else if (holdoff_cnt != '0) begin
            holdoff_cnt <= holdoff_cnt - 1'b1;
        end
    end
`else
    assign holdoff_cnt = '0;
`endif

    // A zero-length window behaves the same as having no hold-off at all.
    assign holdoff_clear = (holdoff_cnt == '0) || (DEBOUNCE_CYCLES == 0);

    assign accept = press & ~enablen & ~clr & digit_ok & has_room & holdoff_clear;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else if (clr) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else if (accept) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= bcd_s2;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            digit_count <= 3'd0;
            entry_state <= ST_EMPTY;
            key_ack     <= 1'b0;
        end else begin
            key_ack <= accept;
            if (clr) begin
                digit_count <= 3'd0;
                entry_state <= ST_EMPTY;
            end else if (accept) begin
                digit_count <= next_count;
                entry_state <= (next_count == 3'd4) ? ST_FULL : ST_ENTRY;
            end
        end
    end

    assign time_zero  = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                        (min_ones == 4'd0) && (min_tens == 4'd0);
    assign time_valid = (sec_tens <= 4'd5);

endmodule

// File: tb/tb_time_entry_register.sv
// Scoreboard bench for time_entry_register: accepted presses push expected digits and ack cycle,
// a negedge monitor pops them whenever key_ack is seen.
module tb_time_entry_register;

    logic       clk;
    logic       resetn;
    logic [3:0] BCD_IN;
    logic       loadn;
    logic       clr;
    logic       enablen;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic [2:0] digit_count;
    logic [1:0] entry_state;
    logic       key_ack;
    logic       time_zero;
    logic       time_valid;

`ifdef DEBOUNCE_EN
    localparam int GAP = 20;
`else
    localparam int GAP = 10;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] digits;
        logic [2:0]  cnt;
    } exp_t;

    exp_t expQ[$];
    int   cyc;
    int   checkCount;
    int   passCount;

    time_entry_register dut (
        .clk         (clk),
        .resetn      (resetn),
        .BCD_IN      (BCD_IN),
        .loadn       (loadn),
        .clr         (clr),
        .enablen     (enablen),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .min_ones    (min_ones),
        .min_tens    (min_tens),
        .digit_count (digit_count),
        .entry_state (entry_state),
        .key_ack     (key_ack),
        .time_zero   (time_zero),
        .time_valid  (time_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] digitsNow();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // One loadn pulse; an expected accept is scheduled for the third edge after the rise.
    task automatic applyStimulus(input logic [3:0] digit, input int hold, input int low,
                                 input bit expAck, input logic [15:0] expDigits, input logic [2:0] expCnt);
        exp_t e;
        @(negedge clk);
        BCD_IN = digit;
        loadn  = 1'b1;
        if (expAck) begin
            e.cyc    = cyc + 3;
            e.digits = expDigits;
            e.cnt    = expCnt;
            expQ.push_back(e);
        end
        repeat (hold) @(negedge clk);
        loadn = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " digits"}, 32'(digitsNow()), 32'h0000);
        checkOutput({tag, " count"}, 32'(digit_count), 32'd0);
        checkOutput({tag, " state"}, 32'(entry_state), 32'd0);
        checkOutput({tag, " key_ack"}, 32'(key_ack), 32'd0);
        checkOutput({tag, " time_zero"}, 32'(time_zero), 32'd1);
        checkOutput({tag, " time_valid"}, 32'(time_valid), 32'd1);
    endtask

    // Monitor: every ack must match the head of the queue in timing and contents.
    always @(negedge clk) begin
        if (key_ack === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_ack: got ack at cycle %0d digits 0x%0h, expected no ack", cyc, digitsNow());
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("ack_cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("ack_digits", 32'(digitsNow()), 32'(e.digits));
                checkOutput("ack_count", 32'(digit_count), 32'(e.cnt));
            end
        end else if (expQ.size() != 0 && cyc > expQ[0].cyc) begin
            exp_t e;
            e = expQ.pop_front();
            checkCount++;
            $display("[TB] FAIL missing_ack: got no ack by cycle %0d, expected ack at cycle %0d", cyc, e.cyc);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cyc        = 0;
        checkCount = 0;
        passCount  = 0;
        resetn     = 1'b0;
        loadn      = 1'b0;
        clr        = 1'b0;
        enablen    = 1'b0;
        BCD_IN     = 4'd0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(4'd1, 4, GAP, 1'b1, 16'h0001, 3'd1);
        applyStimulus(4'd2, 4, GAP, 1'b1, 16'h0012, 3'd2);
        checkOutput("entry_state", 32'(entry_state), 32'd1);
        applyStimulus(4'd3, 4, GAP, 1'b1, 16'h0123, 3'd3);
        applyStimulus(4'd0, 4, GAP, 1'b1, 16'h1230, 3'd4);
        checkOutput("full_state", 32'(entry_state), 32'd2);
        checkOutput("full_valid", 32'(time_valid), 32'd1);
        checkOutput("full_zero", 32'(time_zero), 32'd0);

        applyStimulus(4'd7, 4, GAP, 1'b0, 16'h0, 3'd0);
        checkOutput("full_hold_digits", 32'(digitsNow()), 32'h1230);
        checkOutput("full_hold_count", 32'(digit_count), 32'd4);

        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("clr_digits", 32'(digitsNow()), 32'h0000);
        checkOutput("clr_count", 32'(digit_count), 32'd0);
        checkOutput("clr_state", 32'(entry_state), 32'd0);
        checkOutput("clr_zero", 32'(time_zero), 32'd1);

        applyStimulus(4'd5, 50, GAP, 1'b1, 16'h0005, 3'd1);
        checkOutput("held_count", 32'(digit_count), 32'd1);

        @(negedge clk);
        enablen = 1'b1;
        BCD_IN  = 4'd4;
        loadn   = 1'b1;
        repeat (6) @(negedge clk);
        enablen = 1'b0;
        repeat (6) @(negedge clk);
        loadn = 1'b0;
        repeat (GAP) @(negedge clk);
        checkOutput("enablen_digits", 32'(digitsNow()), 32'h0005);
        checkOutput("enablen_count", 32'(digit_count), 32'd1);
        applyStimulus(4'd4, 4, GAP, 1'b1, 16'h0054, 3'd2);

        applyStimulus(4'd12, 4, GAP, 1'b0, 16'h0, 3'd0);
        checkOutput("bad_digit_digits", 32'(digitsNow()), 32'h0054);
        checkOutput("bad_digit_count", 32'(digit_count), 32'd2);

        // clr lands on the very edge where the press would be accepted.
        @(negedge clk);
        BCD_IN = 4'd9;
        loadn  = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        loadn = 1'b0;
        repeat (GAP) @(negedge clk);
        checkOutput("clr_prio_digits", 32'(digitsNow()), 32'h0000);
        checkOutput("clr_prio_count", 32'(digit_count), 32'd0);

`ifdef DEBOUNCE_EN
        applyStimulus(4'd2, 3, 1, 1'b1, 16'h0002, 3'd1);
        applyStimulus(4'd2, 3, GAP, 1'b0, 16'h0, 3'd0);
        checkOutput("debounce_count", 32'(digit_count), 32'd1);
        applyStimulus(4'd3, 4, GAP, 1'b1, 16'h0023, 3'd2);
        checkOutput("debounce_after_count", 32'(digit_count), 32'd2);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
`endif

        applyStimulus(4'd6, 4, GAP, 1'b1, 16'h0006, 3'd1);
        applyStimulus(4'd7, 4, GAP, 1'b1, 16'h0067, 3'd2);
        checkOutput("sec_tens_6_valid", 32'(time_valid), 32'd0);
        checkOutput("sec_tens_6_digits", 32'(digitsNow()), 32'h0067);

        @(negedge clk);
        BCD_IN = 4'd8;
        loadn  = 1'b1;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 checkResetValues("async_reset");
        loadn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        checkResetValues("post_reset");

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/time_entry_register.md
Name: time_entry_register

Overview:
- Consumer end of the keypad encoder interface. Takes the encoder's BCD digit and its loadn key-valid level, and detects each new key press.
- Shifts accepted digits right-to-left into a 4-digit MM:SS BCD register, like a microwave keypad entry.
- Its outputs feed the countdown timer preload and the display decoder.

Parameters:
- DEBOUNCE_CYCLES, 16, hold-off window in clk cycles after an accepted digit (used only with DEBOUNCE_EN).
- CNT_W, 5, width of the hold-off counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous active-low reset.
- BCD_IN  in  4  digit from the keypad encoder.
- loadn  in  1  encoder key-valid level: 1 while exactly one key is held, 0 otherwise. Asynchronous to clk.
- clr  in  1  synchronous clear of the entry, active-high level.
- enablen  in  1  active-low entry enable; when 1, digits are not accepted (cooking in progress).
- sec_ones, sec_tens, min_ones, min_tens  out  4 each  entered time digits, BCD.
- digit_count  out  3  number of digits entered, 0..4.
- entry_state  out  2  00 EMPTY, 01 ENTRY, 10 FULL.
- key_ack  out  1  one-cycle pulse per accepted digit.
- time_zero  out  1  1 when all four digits are 0.
- time_valid  out  1  1 when sec_tens <= 5.

Behaviour:
- Reset (resetn=0, async): all digits 0, digit_count 0, entry_state EMPTY, key_ack 0, time_zero 1, time_valid 1, synchronizer/edge flops 0, hold-off counter 0.
- Synchronizer: loadn passes through 2 flops (s1, s2), plus s3 for edge detect. BCD_IN passes through a parallel 2-flop pipeline aligned with s2.
- Press event: s2=1 and s3=0.
- Accept condition: press event AND enablen=0 AND clr=0 AND digit <= 9 AND digit_count < 4 AND hold-off counter = 0.
- Accept action, on one clock edge:
  - min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= digit.
  - digit_count += 1.
  - key_ack = 1 for the following cycle.
- Latency: loadn rising before clk edge k → digits update at edge k+2 → key_ack high during cycle k+2..k+3.
- State machine, a function of digit_count:
  - EMPTY (0) → ENTRY on accept.
  - ENTRY (1..3) → FULL when the 4th digit is accepted.
  - FULL: further presses are ignored, no ack.
  - Any state → EMPTY on clr.
- clr: clears digits, digit_count, and the hold-off counter on the next edge. clr has priority over a simultaneous press; that press is discarded, with no ack.
- enablen=1: presses are discarded and the register holds. Edge flops keep tracking, so a key held across enablen 1→0 does not register; a new press is required.
- Held key: exactly one accept per rising edge of loadn, regardless of hold duration.
- Digit 10..15 with a press event: ignored, no ack, no state change.
- time_zero and time_valid are combinational from the digit registers. sec_tens of 6..9 is stored as entered; time_valid=0 flags it for the timer.
- Reset asserted mid-entry: immediate return to reset values. Deassertion has no effect until the next clk edge.

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined: an accept loads the hold-off counter with DEBOUNCE_CYCLES, which decrements to 0 each cycle. Press events while it is nonzero are discarded with no ack; clr zeros it.
- Undefined: no counter; every qualifying press event is accepted.

Test Plan:
- Reset, then press 1,2,3,0 (BCD_IN stable, loadn pulse 4 cycles high, 10 low) → digits 1,2,3,0 = 12:30, digit_count 4, FULL, 4 key_ack pulses each 1 cycle, time_valid 1.
- From FULL 12:30, press 7 → no change, no ack. Then clr for 1 cycle → all 0, EMPTY, time_zero 1.
- Hold key 5 with loadn high for 50 cycles → exactly one accept, sec_ones 5, count 1. Ack appears 2 edges after loadn rise.
- enablen=1, press 4, raise enablen→0 while key still held → no accept. Release and press 4 again → sec_ones 4.
- DEBOUNCE_EN, DEBOUNCE_CYCLES=16: press 2, then a loadn glitch low/high 5 cycles later → only one accept. Press again after 20 cycles → accepted, count 2.
- Press 6 then 7 → sec_tens 6, sec_ones 7, time_valid 0. Assert resetn low mid-sequence → outputs immediately at reset values.
